// File: rtl/mult_acc_pkg.sv
// Shared widths, FSM state type and saturation limits for the product accumulator.
package mult_acc_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;

  typedef enum logic {ST_IDLE, ST_ACCUM} state_e;

  // Limits are returned wide; callers truncate to w bits. The low w bits of
  // 1<<(w-1) are exactly the two's-complement pattern of -2^(w-1).
  function automatic logic [127:0] acc_max(input int w);
    acc_max = (128'd1 << (w - 1)) - 128'd1;
  endfunction

  function automatic logic [127:0] acc_min(input int w);
    acc_min = 128'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/mult_acc_sat_add.sv
// Combinational ACC_W adder: acc + sign-extended product, wrapping or saturating
// depending on MULT_ACC_SATURATE_EN.
module mult_acc_sat_add
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] raw;

  // Replication count is at least 1, so ACC_W == PROD_W needs no special case.
  assign prod_ext = {{(ACC_W-PROD_W+1){prod[PROD_W-1]}}, prod[PROD_W-2:0]};
  assign raw      = acc + prod_ext;

`ifdef MULT_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

  // Overflow only when both operands share a sign and the result flips it.
  always_comb begin
    ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
    sum = raw;
    if (ovf) sum = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
  end
`else
  assign sum = raw;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mult_accumulator.sv
// Accumulates LEN signed products into a wide sum and hands each result off via
// valid/ready. Build with MULT_ACC_SATURATE_EN for saturating adds and overflow flag.
module mult_accumulator
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN    = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy,
  output logic              overrun,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  acc_out_q, acc_out_d;
  logic              acc_valid_q, acc_valid_d;
  logic              overrun_q, overrun_d;
  logic              overflow_q, overflow_d;
  logic [ACC_W-1:0]  sum;
  logic              add_ovf;

  mult_acc_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc  (acc_q),
    .prod (prod),
    .sum  (sum),
    .ovf  (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = acc_valid_q;
    overrun_d   = overrun_q;
    overflow_d  = overflow_q;

    if (acc_valid_q && acc_ready) acc_valid_d = 1'b0;

    if (clear) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      acc_d       = '0;
      acc_out_d   = '0;
      acc_valid_d = 1'b0;
      overrun_d   = 1'b0;
      overflow_d  = 1'b0;
    end else if (prod_valid) begin
      overflow_d = overflow_q | add_ovf;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACCUM;
          cnt_d   = CNT_W'(1);
          acc_d   = sum;
        end
        ST_ACCUM: begin
          if (cnt_q == CNT_LAST) begin
            // A completion that lands on a handshake edge is not an overrun.
            overrun_d   = overrun_q | (acc_valid_q & ~acc_ready);
            acc_out_d   = sum;
            acc_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = sum;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      overrun_q   <= overrun_d;
      overflow_q  <= overflow_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_valid = acc_valid_q;
  assign busy      = (cnt_q != '0);
  assign overrun   = overrun_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Drives three accumulator configurations with shared stimulus and checks them
// every cycle against a plain-arithmetic model plus hand-computed expectations.
module tb_mult_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prod_valid;
  logic [31:0] prod;
  logic        clear;
  logic        acc_ready;

  logic [39:0] out0, out2;
  logic [31:0] out1;
  logic [2:0]  vld, bsy, ovr, ovf;

  int n_checks = 0;
  int n_errors = 0;

  // model state per instance: 0 = (ACC_W 40, LEN 4), 1 = (ACC_W 32, LEN 4), 2 = (ACC_W 40, LEN 2)
  longint m_acc[3], m_out[3];
  int     m_cnt[3];
  bit     m_vld[3], m_ovr[3], m_ovf[3];

  always #5 clk = ~clk;

  mult_accumulator #(.PROD_W(32), .ACC_W(40), .LEN(4), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod(prod), .clear(clear),
    .acc_out(out0), .acc_valid(vld[0]), .acc_ready(acc_ready), .busy(bsy[0]),
    .overrun(ovr[0]), .overflow(ovf[0]));

  mult_accumulator #(.PROD_W(32), .ACC_W(32), .LEN(4), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod(prod), .clear(clear),
    .acc_out(out1), .acc_valid(vld[1]), .acc_ready(acc_ready), .busy(bsy[1]),
    .overrun(ovr[1]), .overflow(ovf[1]));

  mult_accumulator #(.PROD_W(32), .ACC_W(40), .LEN(2), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod(prod), .clear(clear),
    .acc_out(out2), .acc_valid(vld[2]), .acc_ready(acc_ready), .busy(bsy[2]),
    .overrun(ovr[2]), .overflow(ovf[2]));

  function automatic int wof(input int i);
    return (i == 1) ? 32 : 40;
  endfunction

  function automatic int lof(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  function automatic longint get_out(input int i);
    if (i == 0) return longint'($signed(out0));
    if (i == 1) return longint'($signed(out1));
    return longint'($signed(out2));
  endfunction

  function automatic longint wrapw(input longint v, input int w);
    longint m;
    m = (longint'(1) <<< w);
    v = v & (m - 1);
    if (v >= (m >>> 1)) v = v - m;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_out[i] = 0; m_cnt[i] = 0;
      m_vld[i] = 0; m_ovr[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // One clock edge of the specified behaviour, computed with ordinary integers.
  task automatic model_step();
    longint s, p, mx, mn;
    bit was_v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    p = longint'($signed(prod));
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        m_acc[i] = 0; m_out[i] = 0; m_cnt[i] = 0;
        m_vld[i] = 0; m_ovr[i] = 0; m_ovf[i] = 0;
      end else begin
        was_v = m_vld[i];
        if (m_vld[i] && acc_ready) m_vld[i] = 0;
        if (prod_valid) begin
          s  = m_acc[i] + p;
          mx = (longint'(1) <<< (wof(i) - 1)) - 1;
          mn = -mx - 1;
`ifdef MULT_ACC_SATURATE_EN
          if (s > mx) begin s = mx; m_ovf[i] = 1; end
          else if (s < mn) begin s = mn; m_ovf[i] = 1; end
`else
          s = wrapw(s, wof(i));
`endif
          if (m_cnt[i] == lof(i) - 1) begin
            if (was_v && !acc_ready) m_ovr[i] = 1;
            m_out[i] = s;
            m_vld[i] = 1;
            m_acc[i] = 0;
            m_cnt[i] = 0;
          end else begin
            m_acc[i] = s;
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid%0d", i), longint'(vld[i]), longint'(m_vld[i]));
      chk($sformatf("busy%0d", i), longint'(bsy[i]), longint'(m_cnt[i] != 0));
      chk($sformatf("overrun%0d", i), longint'(ovr[i]), longint'(m_ovr[i]));
      chk($sformatf("overflow%0d", i), longint'(ovf[i]), longint'(m_ovf[i]));
      if (m_vld[i]) chk($sformatf("acc_out%0d", i), get_out(i), m_out[i]);
    end
  endtask

  // Inputs are set at the falling edge, the model follows the rising edge,
  // and outputs are compared at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic strobe(input logic [31:0] v);
    prod_valid = 1'b1;
    prod       = v;
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [31:0] vec [4];

  initial begin
    rst_n = 1'b0; prod_valid = 1'b0; prod = '0; clear = 1'b0; acc_ready = 1'b0;
    model_reset();
    @(negedge clk);
    tick();
    chk("rst_valid", longint'(vld[0]), 0);
    chk("rst_busy", longint'(bsy[0]), 0);
    chk("rst_acc_out", get_out(0), 0);
    chk("rst_overrun", longint'(ovr[0]), 0);
    rst_n = 1'b1;
    tick();

    // consecutive strobes, consumer always ready
    acc_ready = 1'b1;
    vec[0] = 32'd65535; vec[1] = 32'd715827882;
    vec[2] = -32'sd357908480; vec[3] = 32'd1065353471;
    for (int k = 0; k < 4; k++) begin
      prod_valid = 1'b1; prod = vec[k];
      tick();
      if (k < 3) chk("t1_busy", longint'(bsy[0]), 1);
    end
    prod_valid = 1'b0;
    chk("t1_valid", longint'(vld[0]), 1);
    chk("t1_acc_out", get_out(0), 1423338408);
    chk("t1_overrun", longint'(ovr[0]), 0);
    tick();
    chk("t1_consumed", longint'(vld[0]), 0);
    do_clear();

    // half-rate strobes, then a fifth product opens a new group
    vec[0] = -32'sd1; vec[1] = 32'd32767; vec[2] = -32'sd32767; vec[3] = 32'd0;
    for (int k = 0; k < 4; k++) begin
      strobe(vec[k]);
      if (k == 3) chk("t2_acc_out", get_out(0), -1);
      tick();
    end
    strobe(32'd7);
    chk("t2_new_group_busy", longint'(bsy[0]), 1);
    do_clear();

    // LEN=2 instance: unconsumed result overwritten
    acc_ready = 1'b0;
    strobe(32'd3); strobe(32'd4); strobe(32'd10); strobe(32'd20);
    chk("t3_acc_out", get_out(2), 30);
    chk("t3_valid", longint'(vld[2]), 1);
    chk("t3_overrun", longint'(ovr[2]), 1);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    chk("t3_consumed", longint'(vld[2]), 0);
    chk("t3_overrun_sticky", longint'(ovr[2]), 1);
    tick();
    do_clear();
    chk("t3_overrun_cleared", longint'(ovr[2]), 0);

    // clear on the second strobe of a group discards it
    acc_ready = 1'b1;
    strobe(32'd5);
    clear = 1'b1;
    strobe(32'd6);
    clear = 1'b0;
    chk("t4_busy", longint'(bsy[0]), 0);
    strobe(32'd1); strobe(32'd2); strobe(32'd3); strobe(32'd4);
    chk("t4_acc_out", get_out(0), 10);
    do_clear();

    // 32-bit accumulator pushed past its range
    for (int k = 0; k < 4; k++) strobe(32'd1073741824);
`ifdef MULT_ACC_SATURATE_EN
    chk("t5_acc_out", get_out(1), 2147483647);
    chk("t5_overflow", longint'(ovf[1]), 1);
`else
    chk("t5_acc_out", get_out(1), 0);
    chk("t5_overflow", longint'(ovf[1]), 0);
`endif
    do_clear();

    // reset in the middle of a group
    acc_ready = 1'b0;
    strobe(32'd9); strobe(32'd9);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_busy", longint'(bsy[0]), 0);
    chk("t6_rst_valid", longint'(vld[2]), 0);
    chk("t6_rst_acc_out", get_out(2), 0);
    chk("t6_rst_overrun", longint'(ovr[2]), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) strobe(32'd5);
    chk("t6_acc_out", get_out(0), 20);
    do_clear();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      prod_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) prod = $urandom;
      else prod = 32'($urandom_range(0, 200)) - 32'd100;
      acc_ready = ($urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 40) == 0);
      tick();
    end
    prod_valid = 1'b0; clear = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
